// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared forwarding-select encodings and hazard FSM state type
package riscv_pipe_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_MEM_ERR} state_t;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline tags/decode fields in, stall/flush/forward controls out
//  master: datapath side (drives decode fields, tags, memory handshake)
//  slave:  hazard controller side (drives stalls, flushes, forwards, MemErr, StallCount)
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic             ResultSrc_E0, PCSrc_E, RegWrite_M, MemReq_M, MemReady_M, RegWrite_W;
    logic             Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, MemErr;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic [CNT_W-1:0] StallCount;
    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        output ResultSrc_E0, PCSrc_E, RegWrite_M, MemReq_M, MemReady_M, RegWrite_W,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, MemErr,
        input  ForwardA_E, ForwardB_E, StallCount
    );
    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
        input  ResultSrc_E0, PCSrc_E, RegWrite_M, MemReq_M, MemReady_M, RegWrite_W,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, MemErr,
        output ForwardA_E, ForwardB_E, StallCount
    );
endinterface

// File: rtl/forward_unit.sv
// forward_unit: E-stage operand bypass select for one source register
//  rs: E-stage source; rd_m/reg_write_m, rd_w/reg_write_w: producer tags; fwd: select
module forward_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    // M is the younger producer so it wins; x0 is hardwired zero and never bypassed
    always_comb
        fwd = (reg_write_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
              (reg_write_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_NONE;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush sequencer, operand forwarding and memory watchdog
//  clk, rst: clock and synchronous active-high reset
//  hz:       slave side of hazard_controller_if (tags in, controls/MemErr/StallCount out)
module hazard_controller
    import riscv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_controller_if.slave hz
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    state_t           state;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err, mem_wait, lw_stall, frozen, stall_f;
    logic [1:0]       fwd_a, fwd_b;
    forward_unit fu_a (.rs(hz.Rs1_E), .rd_m(hz.Rd_M), .reg_write_m(hz.RegWrite_M),
                       .rd_w(hz.Rd_W), .reg_write_w(hz.RegWrite_W), .fwd(fwd_a));
    forward_unit fu_b (.rs(hz.Rs2_E), .rd_m(hz.Rd_M), .reg_write_m(hz.RegWrite_M),
                       .rd_w(hz.Rd_W), .reg_write_w(hz.RegWrite_W), .fwd(fwd_b));
    // frozen: whole pipe held; a pending branch stays in the held E stage until release
    always_comb begin
        mem_wait      = hz.MemReq_M & ~hz.MemReady_M;
        lw_stall      = hz.ResultSrc_E0 & (hz.Rd_E != 5'd0) & (hz.Rd_E == hz.Rs1_D | hz.Rd_E == hz.Rs2_D);
        frozen        = (state == ST_MEM_ERR) | mem_wait;
        stall_f       = ~rst & (frozen | (~hz.PCSrc_E & lw_stall));
        hz.Stall_F    = stall_f;
        hz.Stall_D    = stall_f;
        hz.Stall_E    = ~rst & frozen;
        hz.Stall_M    = ~rst & frozen;
        hz.Bubble_W   = rst | frozen;
        hz.Flush_D    = rst | (~frozen & hz.PCSrc_E);
        hz.Flush_E    = rst | (~frozen & (hz.PCSrc_E | lw_stall));
        hz.ForwardA_E = rst ? FWD_NONE : fwd_a;
        hz.ForwardB_E = rst ? FWD_NONE : fwd_b;
        hz.MemErr     = mem_err;
        hz.StallCount = stall_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            if (stall_f && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
            case (state)
                ST_RUN: if (mem_wait) begin
                    state    <= ST_MEM_WAIT;
                    wait_cnt <= WW'(1);
                end
                ST_MEM_WAIT: if (hz.MemReady_M) begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                        state   <= ST_MEM_ERR;
                        mem_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed + randomized checks of hazard_controller against a behavioural model
module tb_hazard_controller;
    localparam int T = 4;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    hazard_controller_if #(.CNT_W(W)) hz ();
    hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (.clk(clk), .rst(rst), .hz(hz));
    int checks = 0, errors = 0;
    bit m_err, m_wait, e_sf;
    int m_run, m_cnt;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [1:0] fwd_ref(logic [4:0] x);
        if (hz.RegWrite_M && hz.Rd_M == x && x != 0) return 2'b10;
        if (hz.RegWrite_W && hz.Rd_W == x && x != 0) return 2'b01;
        return 2'b00;
    endfunction
    task automatic clr();
        {hz.Rs1_D, hz.Rs2_D, hz.Rs1_E, hz.Rs2_E, hz.Rd_E, hz.Rd_M, hz.Rd_W} = '0;
        {hz.ResultSrc_E0, hz.PCSrc_E, hz.RegWrite_M, hz.MemReq_M, hz.MemReady_M, hz.RegWrite_W} = '0;
    endtask
    // Expected outputs for the current inputs, checked mid-cycle
    task automatic settle();
        bit mw, lw, hold;
        logic [3:0] es;
        logic [2:0] ef;
        #4;
        mw = hz.MemReq_M && !hz.MemReady_M;
        lw = hz.ResultSrc_E0 && hz.Rd_E != 0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
        hold = m_err || mw;
        if (rst)               begin es = 4'b0000; ef = 3'b111; end
        else if (hold)         begin es = 4'b1111; ef = 3'b001; end
        else if (hz.PCSrc_E)   begin es = 4'b0000; ef = 3'b110; end
        else if (lw)           begin es = 4'b1100; ef = 3'b010; end
        else                   begin es = 4'b0000; ef = 3'b000; end
        e_sf = es[3];
        chk("stalls_FDEM", {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M}, es);
        chk("flushD_flushE_bubbleW", {hz.Flush_D, hz.Flush_E, hz.Bubble_W}, ef);
        chk("ForwardA_E", hz.ForwardA_E, rst ? 2'b00 : fwd_ref(hz.Rs1_E));
        chk("ForwardB_E", hz.ForwardB_E, rst ? 2'b00 : fwd_ref(hz.Rs2_E));
        chk("MemErr", hz.MemErr, m_err);
        chk("StallCount", hz.StallCount, m_cnt);
    endtask
    // Advance the model across the clock edge using the inputs of the cycle just checked
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_err = 0; m_wait = 0; m_run = 0; m_cnt = 0;
        end else begin
            if (e_sf && m_cnt < (1 << W) - 1) m_cnt++;
            if (!m_err) begin
                if (!m_wait) begin
                    if (hz.MemReq_M && !hz.MemReady_M) begin m_wait = 1; m_run = 1; end
                end else if (hz.MemReady_M) begin
                    m_wait = 0; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run >= T) m_err = 1;
                end
            end
        end
        #1;
    endtask
    task automatic cycle();
        settle();
        tick();
    endtask
    initial begin
        rst = 1'b1;
        clr();
        cycle();
        cycle();
        rst = 1'b0;
        hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1; hz.Rd_W = 5; hz.RegWrite_W = 1;
        settle();
        chk("fwdA_m_over_w", hz.ForwardA_E, 2'b10);
        tick();
        clr();
        hz.Rd_M = 0; hz.RegWrite_M = 1; hz.Rs2_E = 0;
        settle();
        chk("fwdB_x0", hz.ForwardB_E, 2'b00);
        tick();
        clr();
        hz.ResultSrc_E0 = 1; hz.Rd_E = 7; hz.Rs2_D = 7;
        settle();
        chk("lw_stall", {hz.Stall_F, hz.Stall_D, hz.Flush_E, hz.Stall_E}, 4'b1110);
        tick();
        clr();
        cycle();
        hz.ResultSrc_E0 = 1; hz.Rd_E = 7; hz.Rs1_D = 7; hz.PCSrc_E = 1;
        settle();
        chk("squash_beats_lw", {hz.Flush_D, hz.Flush_E, hz.Stall_F}, 3'b110);
        tick();
        clr();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        hz.MemReq_M = 1;
        repeat (3) cycle();
        hz.MemReady_M = 1;
        cycle();
        clr();
        settle();
        chk("mem_wait_count3", hz.StallCount, 3);
        tick();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        hz.MemReq_M = 1;
        repeat (4) cycle();
        settle();
        chk("memerr_cycle5", hz.MemErr, 1);
        tick();
        clr();
        repeat (15) cycle();
        settle();
        chk("stallcount_saturates", hz.StallCount, (1 << W) - 1);
        tick();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        settle();
        chk("rst_clears_memerr", hz.MemErr, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            hz.Rs1_D = 5'($urandom_range(0, 3));
            hz.Rs2_D = 5'($urandom_range(0, 3));
            hz.Rs1_E = 5'($urandom_range(0, 3));
            hz.Rs2_E = 5'($urandom_range(0, 3));
            hz.Rd_E = 5'($urandom_range(0, 3));
            hz.Rd_M = 5'($urandom_range(0, 3));
            hz.Rd_W = 5'($urandom_range(0, 3));
            hz.ResultSrc_E0 = 1'($urandom_range(0, 1));
            hz.PCSrc_E = ($urandom_range(0, 3) == 0);
            hz.RegWrite_M = 1'($urandom_range(0, 1));
            hz.RegWrite_W = 1'($urandom_range(0, 1));
            hz.MemReq_M = ($urandom_range(0, 3) == 0);
            hz.MemReady_M = ($urandom_range(0, 9) < 4);
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
